muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_sequencer.sv | 179 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M sequencer: shift-add multiplier and restoring divider,
// one iteration per clock, with BUSY stall, one-cycle DONE pulse and held RESULT.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [4:0]       SELECT,
   input  logic [WIDTH-1:0] DATA1,
   input  logic [WIDTH-1:0] DATA2,
   input  logic             ABORT,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] RESULT
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [4:0] OP_MUL    = 5'b01011;
   localparam logic [4:0] OP_MULH   = 5'b01100;
   localparam logic [4:0] OP_MULHSU = 5'b01101;
   localparam logic [4:0] OP_MULHU  = 5'b01110;
   localparam logic [4:0] OP_DIV    = 5'b01111;
   localparam logic [4:0] OP_DIVU   = 5'b10000;
   localparam logic [4:0] OP_REM    = 5'b10001;
   localparam logic [4:0] OP_REMU   = 5'b10010;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [4:0]         op_q, op_d;
   logic               neg_q, neg_d;
   logic               neg_rem_q, neg_rem_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quot_q, quot_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   result_q, result_d;

   // Request decode on the live inputs (only meaningful in IDLE)
   logic             is_m, is_div, s1_signed, s2_signed, sign1, sign2;
   logic             div_zero, div_ovf;
   logic [WIDTH-1:0] mag1, mag2;

   always_comb begin
      is_m      = (SELECT >= OP_MUL) && (SELECT <= OP_REMU);
      is_div    = (SELECT >= OP_DIV) && (SELECT <= OP_REMU);
      s1_signed = (SELECT == OP_MULH) || (SELECT == OP_MULHSU) ||
                  (SELECT == OP_DIV)  || (SELECT == OP_REM);
      s2_signed = (SELECT == OP_MULH) || (SELECT == OP_DIV) || (SELECT == OP_REM);
      sign1     = s1_signed && DATA1[WIDTH-1];
      sign2     = s2_signed && DATA2[WIDTH-1];
      mag1      = sign1 ? -DATA1 : DATA1;
      mag2      = sign2 ? -DATA2 : DATA2;
      div_zero  = is_div && (DATA2 == '0);
      div_ovf   = ((SELECT == OP_DIV) || (SELECT == OP_REM)) &&
                  (DATA1 == {1'b1, {(WIDTH-1){1'b0}}}) && (DATA2 == '1);
   end

   // One iteration of each datapath, from the latched state
   logic             op_is_div;
   logic [WIDTH:0]   mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0] acc_step, prod;
   logic [WIDTH-1:0] quot_signed, rem_signed, fin_result;

   always_comb begin
      op_is_div   = (op_q >= OP_DIV);
      mul_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      acc_step    = {mul_sum, acc_q[WIDTH-1:1]};
      div_shift   = {rem_q, quot_q[WIDTH-1]};
      div_diff    = div_shift - {1'b0, opnd_q};
      prod        = neg_q ? -acc_q : acc_q;
      quot_signed = neg_q ? -quot_q : quot_q;
      rem_signed  = neg_rem_q ? -rem_q : rem_q;
      case (op_q)
         OP_MUL:                      fin_result = prod[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fin_result = prod[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:             fin_result = quot_signed;
         default:                     fin_result = rem_signed;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      rem_d     = rem_q;
      quot_d    = quot_q;
      done_d    = 1'b0;
      result_d  = result_q;
      case (state_q)
         S_IDLE: begin
            if (START && !ABORT && is_m) begin
               op_d  = SELECT;
               cnt_d = '0;
               if (div_zero || div_ovf) begin
                  // Special results bypass iteration; sign fixup is disabled
                  state_d   = S_FIN;
                  neg_d     = 1'b0;
                  neg_rem_d = 1'b0;
                  acc_d     = '0;
                  quot_d    = div_zero ? '1 : {1'b1, {(WIDTH-1){1'b0}}};
                  rem_d     = div_zero ? DATA1 : '0;
               end else begin
                  state_d   = S_CALC;
                  neg_d     = sign1 ^ sign2;
                  neg_rem_d = sign1;
                  acc_d     = {{WIDTH{1'b0}}, mag2};
                  opnd_d    = is_div ? mag2 : mag1;
                  quot_d    = mag1;
                  rem_d     = '0;
               end
            end
         end
         S_CALC: begin
            if (ABORT) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (op_is_div) begin
                  rem_d  = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                  quot_d = {quot_q[WIDTH-2:0], ~div_diff[WIDTH]};
               end else begin
                  acc_d = acc_step;
               end
               if (cnt_q == CW'(WIDTH-1)) state_d = S_FIN;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
            if (!ABORT) begin
               done_d   = 1'b1;
               result_d = fin_result;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         acc_q     <= '0;
         opnd_q    <= '0;
         rem_q     <= '0;
         quot_q    <= '0;
         done_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         rem_q     <= rem_d;
         quot_q    <= quot_d;
         done_q    <= done_d;
         result_q  <= result_d;
      end
   end

   assign BUSY   = (state_q != S_IDLE);
   assign DONE   = done_q;
   assign RESULT = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, results, special cases, abort and reset.
module tb_muldiv_sequencer;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        START = 1'b0;
   logic [4:0]  SELECT = 5'd0;
   logic [31:0] DATA1 = 32'd0;
   logic [31:0] DATA2 = 32'd0;
   logic        ABORT = 1'b0;
   logic        BUSY, DONE;
   logic [31:0] RESULT;

   int pass_cnt = 0;
   int total_cnt = 0;

   localparam logic [4:0] OP_MUL = 5'b01011, OP_MULH = 5'b01100, OP_MULHSU = 5'b01101,
                          OP_MULHU = 5'b01110, OP_DIV = 5'b01111, OP_DIVU = 5'b10000,
                          OP_REM = 5'b10001, OP_REMU = 5'b10010;

   muldiv_sequencer #(.WIDTH(32)) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .SELECT(SELECT),
      .DATA1(DATA1), .DATA2(DATA2), .ABORT(ABORT),
      .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
   );

   always #5 CLK = ~CLK;

   // Issues one op from a post-edge point; returns at post-edge of the DONE cycle
   // (or after a cycle budget). Scrambles the operand inputs once accepted.
   task automatic launch_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                            output int lat, output int busy_lo, output logic [31:0] res,
                            output logic busy_at_done);
      SELECT = sel; DATA1 = a; DATA2 = b; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      DATA1 = $urandom; DATA2 = $urandom; SELECT = OP_MULHU;
      lat = 0; busy_lo = 0;
      while (!DONE && lat < 60) begin
         if (!BUSY) busy_lo++;
         @(posedge CLK); #1;
         lat++;
      end
      res = RESULT;
      busy_at_done = BUSY;
      $display("op sel=%b a=%h b=%h -> result=%h latency=%0d done=%b", sel, a, b, res, lat, DONE);
   endtask

   task automatic test_reset;
      @(posedge CLK); #1;
      total_cnt++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", BUSY); else pass_cnt++;
      total_cnt++; if (DONE !== 1'b0) $display("FAIL reset_done: got %b want 0", DONE); else pass_cnt++;
      total_cnt++; if (RESULT !== 32'd0) $display("FAIL reset_result: got %h want 0", RESULT); else pass_cnt++;
      RESET = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic test_mul;
      int lat, blo; logic [31:0] r; logic bd;
      launch_op(OP_MUL, 32'd7, 32'hFFFFFFFD, lat, blo, r, bd);
      total_cnt++; if (lat !== 33) $display("FAIL mul_latency: got %0d want 33", lat); else pass_cnt++;
      total_cnt++; if (blo !== 0) $display("FAIL mul_busy_gap: got %0d idle cycles want 0", blo); else pass_cnt++;
      total_cnt++; if (bd !== 1'b0) $display("FAIL mul_busy_in_done: got %b want 0", bd); else pass_cnt++;
      total_cnt++; if (r !== 32'hFFFFFFEB) $display("FAIL mul_result: got %h want ffffffeb", r); else pass_cnt++;
      @(posedge CLK); #1;
      total_cnt++; if (DONE !== 1'b0) $display("FAIL done_one_cycle: got %b want 0", DONE); else pass_cnt++;
      total_cnt++; if (RESULT !== 32'hFFFFFFEB) $display("FAIL result_hold: got %h want ffffffeb", RESULT); else pass_cnt++;
      launch_op(OP_MULH, 32'h80000000, 32'h80000000, lat, blo, r, bd);
      total_cnt++; if (r !== 32'h40000000) $display("FAIL mulh: got %h want 40000000", r); else pass_cnt++;
      launch_op(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, blo, r, bd);
      total_cnt++; if (r !== 32'hFFFFFFFF) $display("FAIL mulhsu: got %h want ffffffff", r); else pass_cnt++;
      launch_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, blo, r, bd);
      total_cnt++; if (r !== 32'hFFFFFFFE) $display("FAIL mulhu: got %h want fffffffe", r); else pass_cnt++;
      launch_op(OP_MULH, 32'hFFFFFFFE, 32'd3, lat, blo, r, bd);
      total_cnt++; if (r !== 32'hFFFFFFFF) $display("FAIL mulh_neg: got %h want ffffffff", r); else pass_cnt++;
   endtask

   task automatic test_div;
      int lat, blo; logic [31:0] r; logic bd;
      launch_op(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, blo, r, bd);
      total_cnt++; if (r !== 32'hFFFFFFFD) $display("FAIL div_signed: got %h want fffffffd", r); else pass_cnt++;
      total_cnt++; if (lat !== 33) $display("FAIL div_latency: got %0d want 33", lat); else pass_cnt++;
      launch_op(OP_REM, 32'hFFFFFFF9, 32'd2, lat, blo, r, bd);
      total_cnt++; if (r !== 32'hFFFFFFFF) $display("FAIL rem_signed: got %h want ffffffff", r); else pass_cnt++;
      launch_op(OP_DIVU, 32'd100, 32'd7, lat, blo, r, bd);
      total_cnt++; if (r !== 32'd14) $display("FAIL divu: got %h want 0000000e", r); else pass_cnt++;
      launch_op(OP_REMU, 32'd100, 32'd7, lat, blo, r, bd);
      total_cnt++; if (r !== 32'd2) $display("FAIL remu: got %h want 00000002", r); else pass_cnt++;
      launch_op(OP_REM, 32'd7, 32'hFFFFFFFE, lat, blo, r, bd);
      total_cnt++; if (r !== 32'd1) $display("FAIL rem_pos_dividend: got %h want 00000001", r); else pass_cnt++;
   endtask

   task automatic test_special;
      int lat, blo; logic [31:0] r; logic bd;
      launch_op(OP_DIV, 32'd5, 32'd0, lat, blo, r, bd);
      total_cnt++; if (lat !== 1) $display("FAIL div0_latency: got %0d want 1", lat); else pass_cnt++;
      total_cnt++; if (r !== 32'hFFFFFFFF) $display("FAIL div0: got %h want ffffffff", r); else pass_cnt++;
      launch_op(OP_REM, 32'd5, 32'd0, lat, blo, r, bd);
      total_cnt++; if (r !== 32'd5) $display("FAIL rem0: got %h want 00000005", r); else pass_cnt++;
      launch_op(OP_DIVU, 32'h12345678, 32'd0, lat, blo, r, bd);
      total_cnt++; if (r !== 32'hFFFFFFFF) $display("FAIL divu0: got %h want ffffffff", r); else pass_cnt++;
      launch_op(OP_REMU, 32'h80000001, 32'd0, lat, blo, r, bd);
      total_cnt++; if (r !== 32'h80000001) $display("FAIL remu0: got %h want 80000001", r); else pass_cnt++;
      launch_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, blo, r, bd);
      total_cnt++; if (lat !== 1) $display("FAIL ovf_latency: got %0d want 1", lat); else pass_cnt++;
      total_cnt++; if (r !== 32'h80000000) $display("FAIL div_ovf: got %h want 80000000", r); else pass_cnt++;
      launch_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, lat, blo, r, bd);
      total_cnt++; if (r !== 32'd0) $display("FAIL rem_ovf: got %h want 00000000", r); else pass_cnt++;
   endtask

   task automatic test_abort;
      int lat, blo; logic [31:0] r; logic bd; logic done_seen;
      launch_op(OP_DIVU, 32'd100, 32'd7, lat, blo, r, bd);
      total_cnt++; if (r !== 32'd14) $display("FAIL abort_setup: got %h want 0000000e", r); else pass_cnt++;
      SELECT = OP_DIV; DATA1 = 32'd1000; DATA2 = 32'd3; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      repeat (9) @(posedge CLK);
      #1;
      ABORT = 1'b1;
      @(posedge CLK); #1;
      ABORT = 1'b0;
      total_cnt++; if (BUSY !== 1'b0) $display("FAIL abort_busy: got %b want 0", BUSY); else pass_cnt++;
      done_seen = 1'b0;
      repeat (30) begin
         if (DONE) done_seen = 1'b1;
         @(posedge CLK); #1;
      end
      total_cnt++; if (done_seen !== 1'b0) $display("FAIL abort_no_done: got %b want 0", done_seen); else pass_cnt++;
      total_cnt++; if (RESULT !== 32'd14) $display("FAIL abort_result: got %h want 0000000e", RESULT); else pass_cnt++;
      launch_op(OP_DIVU, 32'd9, 32'd3, lat, blo, r, bd);
      total_cnt++; if (r !== 32'd3) $display("FAIL after_abort: got %h want 00000003", r); else pass_cnt++;
      // Abort while in the finish state of a special case
      SELECT = OP_DIV; DATA1 = 32'd5; DATA2 = 32'd0; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0; ABORT = 1'b1;
      @(posedge CLK); #1;
      ABORT = 1'b0;
      total_cnt++; if (DONE !== 1'b0) $display("FAIL abort_fin_done: got %b want 0", DONE); else pass_cnt++;
      total_cnt++; if (RESULT !== 32'd3) $display("FAIL abort_fin_result: got %h want 00000003", RESULT); else pass_cnt++;
      // ABORT and START together in IDLE: nothing accepted
      SELECT = OP_MUL; DATA1 = 32'd2; DATA2 = 32'd2; START = 1'b1; ABORT = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0; ABORT = 1'b0;
      total_cnt++; if (BUSY !== 1'b0) $display("FAIL abort_start_idle: got busy %b want 0", BUSY); else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      int lat, blo; logic [31:0] r; logic bd;
      launch_op(OP_DIVU, 32'd100, 32'd7, lat, blo, r, bd);
      total_cnt++; if (r !== 32'd14) $display("FAIL b2b_first: got %h want 0000000e", r); else pass_cnt++;
      launch_op(OP_REMU, 32'd100, 32'd7, lat, blo, r, bd);
      total_cnt++; if (lat !== 33) $display("FAIL b2b_latency: got %0d want 33", lat); else pass_cnt++;
      total_cnt++; if (r !== 32'd2) $display("FAIL b2b_second: got %h want 00000002", r); else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      SELECT = OP_MUL; DATA1 = 32'd3; DATA2 = 32'd5; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      repeat (5) @(posedge CLK);
      #2;
      RESET = 1'b1;
      #1;
      total_cnt++; if (BUSY !== 1'b0) $display("FAIL midreset_busy: got %b want 0", BUSY); else pass_cnt++;
      total_cnt++; if (RESULT !== 32'd0) $display("FAIL midreset_result: got %h want 0", RESULT); else pass_cnt++;
      total_cnt++; if (DONE !== 1'b0) $display("FAIL midreset_done: got %b want 0", DONE); else pass_cnt++;
      @(posedge CLK); #1;
      RESET = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic test_invalid;
      logic busy_seen;
      SELECT = 5'b00001; DATA1 = 32'd4; DATA2 = 32'd4; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      busy_seen = 1'b0;
      repeat (4) begin
         if (BUSY || DONE) busy_seen = 1'b1;
         @(posedge CLK); #1;
      end
      total_cnt++; if (busy_seen !== 1'b0) $display("FAIL invalid_opcode: got activity %b want 0", busy_seen); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      test_invalid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
